// File: rtl/time_of_day_mode_ctrl.sv
// time_of_day_mode_ctrl
//   Time-of-day keeper with a day/night mode controller. One-second ticks are
//   counted into minutes and hours. A day/night request is decoded from the
//   hour against a daytime window. The requested mode is applied only while
//   the intersection reports a safe switch point, so a change never cuts into
//   a running phase.
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   tickIn          one-cycle enable, once per second
//   loadEn          load loadHours/loadMinutes this cycle (discards tickIn)
//   loadHours       hour to load, 0-23 (larger values ignore the load)
//   loadMinutes     minute to load, 0-59 (larger values ignore the load)
//   safeIn          intersection is at a safe switch point (all-red)
//   hoursOut        current hour
//   minutesOut      current minute
//   dayReq          requested mode decoded from hoursOut (1 = day)
//   isDay           applied mode (1 = day)
//   pendingOut      mode change requested but not yet applied
//   modeChangePulse one cycle, in the first cycle isDay shows its new value
//
// state    | meaning
// NIGHT    | night applied, no change requested
// TO_DAY   | night applied, day requested, waiting for safeIn
// DAY      | day applied, no change requested
// TO_NIGHT | day applied, night requested, waiting for safeIn

module time_of_day_mode_ctrl #(
   parameter int TICKS_PER_MIN  = 60,
   parameter int DAY_START_HOUR = 6,
   parameter int DAY_END_HOUR   = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tickIn,
   input  logic       loadEn,
   input  logic [4:0] loadHours,
   input  logic [5:0] loadMinutes,
   input  logic       safeIn,
   output logic [4:0] hoursOut,
   output logic [5:0] minutesOut,
   output logic       dayReq,
   output logic       isDay,
   output logic       pendingOut,
   output logic       modeChangePulse
);

   localparam int CW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_MIN - 1);
   localparam logic [4:0] START_H = 5'(DAY_START_HOUR);
   localparam logic [4:0] END_H   = 5'(DAY_END_HOUR);

   typedef enum logic [1:0] {
      NIGHT    = 2'd0,
      TO_DAY   = 2'd1,
      DAY      = 2'd2,
      TO_NIGHT = 2'd3
   } state_t;

   logic [CW-1:0] tickCnt;
   logic          loadValid;
   state_t        stateQ, stateD;
   logic          pulseD;

   assign loadValid = loadEn && (loadHours <= 5'd23) && (loadMinutes <= 6'd59);

   // Any loadEn cycle swallows the tick, even when the load itself is rejected.
   always_ff @(posedge clk) begin
      if (rst) begin
         tickCnt    <= '0;
         hoursOut   <= '0;
         minutesOut <= '0;
      end else if (loadEn) begin
         if (loadValid) begin
            tickCnt    <= '0;
            hoursOut   <= loadHours;
            minutesOut <= loadMinutes;
         end
      end else if (tickIn) begin
         if (tickCnt == TICK_LAST) begin
            tickCnt <= '0;
            if (minutesOut == 6'd59) begin
               minutesOut <= '0;
               hoursOut   <= (hoursOut == 5'd23) ? 5'd0 : hoursOut + 5'd1;
            end else begin
               minutesOut <= minutesOut + 6'd1;
            end
         end else begin
            tickCnt <= tickCnt + 1'b1;
         end
      end
   end

   // A window with START > END spans midnight; an empty window never asks for day.
   always_comb begin
      dayReq = 1'b0;
      if (DAY_START_HOUR < DAY_END_HOUR)
         dayReq = (hoursOut >= START_H) && (hoursOut < END_H);
      else if (DAY_START_HOUR > DAY_END_HOUR)
         dayReq = (hoursOut >= START_H) || (hoursOut < END_H);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ          <= NIGHT;
         modeChangePulse <= 1'b0;
      end else begin
         stateQ          <= stateD;
         modeChangePulse <= pulseD;
      end
   end

   // A withdrawn request returns to the stable state without a pulse.
   always_comb begin
      stateD = stateQ;
      pulseD = 1'b0;
      case (stateQ)
         NIGHT: begin
            if (dayReq && safeIn) begin
               stateD = DAY;
               pulseD = 1'b1;
            end else if (dayReq) begin
               stateD = TO_DAY;
            end
         end
         TO_DAY: begin
            if (!dayReq) begin
               stateD = NIGHT;
            end else if (safeIn) begin
               stateD = DAY;
               pulseD = 1'b1;
            end
         end
         DAY: begin
            if (!dayReq && safeIn) begin
               stateD = NIGHT;
               pulseD = 1'b1;
            end else if (!dayReq) begin
               stateD = TO_NIGHT;
            end
         end
         TO_NIGHT: begin
            if (dayReq) begin
               stateD = DAY;
            end else if (safeIn) begin
               stateD = NIGHT;
               pulseD = 1'b1;
            end
         end
         default: stateD = NIGHT;
      endcase
   end

   assign isDay      = (stateQ == DAY) || (stateQ == TO_NIGHT);
   assign pendingOut = (stateQ == TO_DAY) || (stateQ == TO_NIGHT);

endmodule

// File: tb/tb_time_of_day_mode_ctrl.sv
module tb_time_of_day_mode_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tickIn = 1'b0;
   logic       loadEn = 1'b0;
   logic [4:0] loadHours = '0;
   logic [5:0] loadMinutes = '0;
   logic       safeIn = 1'b0;

   // instance 0: TICKS_PER_MIN=1, window 6..20; instance 1: TICKS_PER_MIN=3, window 22..2
   logic [4:0] h0, h1;
   logic [5:0] m0, m1;
   logic       dr0, dr1, day0, day1, pend0, pend1, pul0, pul1;

   time_of_day_mode_ctrl #(.TICKS_PER_MIN(1), .DAY_START_HOUR(6), .DAY_END_HOUR(20)) dut0 (
      .clk(clk), .rst(rst), .tickIn(tickIn), .loadEn(loadEn), .loadHours(loadHours),
      .loadMinutes(loadMinutes), .safeIn(safeIn), .hoursOut(h0), .minutesOut(m0),
      .dayReq(dr0), .isDay(day0), .pendingOut(pend0), .modeChangePulse(pul0));

   time_of_day_mode_ctrl #(.TICKS_PER_MIN(3), .DAY_START_HOUR(22), .DAY_END_HOUR(2)) dut1 (
      .clk(clk), .rst(rst), .tickIn(tickIn), .loadEn(loadEn), .loadHours(loadHours),
      .loadMinutes(loadMinutes), .safeIn(safeIn), .hoursOut(h1), .minutesOut(m1),
      .dayReq(dr1), .isDay(day1), .pendingOut(pend1), .modeChangePulse(pul1));

   always #5 clk = ~clk;

   int passCnt = 0;
   int totalCnt = 0;

   task automatic check(input string name, input int act, input int req);
      totalCnt++;
      if (act !== req)
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      else
         passCnt++;
   endtask

   // Reference model: time as minutes since midnight, mode as plain flags.
   int tpm[2]   = '{1, 3};
   int startH[2] = '{6, 22};
   int endH[2]   = '{20, 2};
   int mTime[2], mTick[2];
   bit mDay[2], mPend[2], mPulse[2];

   function automatic bit inWindow(input int h, input int s, input int e);
      if (s < e) return (h >= s) && (h < e);
      if (s > e) return (h >= s) || (h < e);
      return 1'b0;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         mTime[i] = 0; mTick[i] = 0; mDay[i] = 0; mPend[i] = 0; mPulse[i] = 0;
      end
   endtask

   task automatic compareModel();
      check("m0.hours",   int'(h0),   mTime[0] / 60);
      check("m0.minutes", int'(m0),   mTime[0] % 60);
      check("m0.dayReq",  int'(dr0),  int'(inWindow(mTime[0] / 60, startH[0], endH[0])));
      check("m0.isDay",   int'(day0), int'(mDay[0]));
      check("m0.pending", int'(pend0), int'(mPend[0]));
      check("m0.pulse",   int'(pul0), int'(mPulse[0]));
      check("m1.hours",   int'(h1),   mTime[1] / 60);
      check("m1.minutes", int'(m1),   mTime[1] % 60);
      check("m1.dayReq",  int'(dr1),  int'(inWindow(mTime[1] / 60, startH[1], endH[1])));
      check("m1.isDay",   int'(day1), int'(mDay[1]));
      check("m1.pending", int'(pend1), int'(mPend[1]));
      check("m1.pulse",   int'(pul1), int'(mPulse[1]));
   endtask

   // One clock edge: advance the model with the inputs seen at the edge, then compare.
   task automatic step();
      bit req;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            mTime[i] = 0; mTick[i] = 0; mDay[i] = 0; mPend[i] = 0; mPulse[i] = 0;
         end else begin
            req = inWindow(mTime[i] / 60, startH[i], endH[i]);
            mPulse[i] = 0;
            if (req != mDay[i]) begin
               if (safeIn) begin
                  mDay[i] = req; mPulse[i] = 1; mPend[i] = 0;
               end else begin
                  mPend[i] = 1;
               end
            end else begin
               mPend[i] = 0;
            end
            if (loadEn) begin
               if (loadHours <= 23 && loadMinutes <= 59) begin
                  mTime[i] = int'(loadHours) * 60 + int'(loadMinutes);
                  mTick[i] = 0;
               end
            end else if (tickIn) begin
               mTick[i]++;
               if (mTick[i] == tpm[i]) begin
                  mTick[i] = 0;
                  mTime[i] = (mTime[i] + 1) % 1440;
               end
            end
         end
      end
      #1;
      compareModel();
   endtask

   task automatic drive(input bit r, input bit ld, input int lh, input int lm,
                        input bit tk, input bit sf);
      rst = r; loadEn = ld; loadHours = 5'(lh); loadMinutes = 6'(lm); tickIn = tk; safeIn = sf;
   endtask

   typedef struct {
      bit r, ld; int lh, lm; bit tk, sf;
      int eh, em; bit edr, eday, epend, epul;
   } vec_t;
   vec_t vecs[$];

   task automatic addv(input bit r, input bit ld, input int lh, input int lm, input bit tk,
                       input bit sf, input int eh, input int em, input bit edr,
                       input bit eday, input bit epend, input bit epul);
      vec_t v;
      v.r = r; v.ld = ld; v.lh = lh; v.lm = lm; v.tk = tk; v.sf = sf;
      v.eh = eh; v.em = em; v.edr = edr; v.eday = eday; v.epend = epend; v.epul = epul;
      vecs.push_back(v);
   endtask

   initial begin
      modelReset();
      //   rst ld  lh  lm tk sf | h  m  dr day pnd pul   (instance 0, after the edge)
      addv(1, 0,  0,  0, 1, 0,  0, 0, 0, 0, 0, 0);
      addv(1, 0,  0,  0, 1, 0,  0, 0, 0, 0, 0, 0);
      addv(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
      addv(0, 1, 19, 59, 0, 1, 19,59, 1, 0, 0, 0);
      addv(0, 0,  0,  0, 0, 1, 19,59, 1, 1, 0, 1);
      addv(0, 0,  0,  0, 0, 1, 19,59, 1, 1, 0, 0);
      addv(0, 0,  0,  0, 1, 1, 20, 0, 0, 1, 0, 0);
      addv(0, 0,  0,  0, 0, 1, 20, 0, 0, 0, 0, 1);
      addv(0, 0,  0,  0, 0, 1, 20, 0, 0, 0, 0, 0);
      addv(0, 1,  5, 59, 0, 0,  5,59, 0, 0, 0, 0);
      addv(0, 0,  0,  0, 1, 0,  6, 0, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++)
         addv(0, 0, 0, 0, 0, 0,  6, 0, 1, 0, 1, 0);
      addv(0, 0,  0,  0, 0, 1,  6, 0, 1, 1, 0, 1);
      addv(0, 0,  0,  0, 0, 1,  6, 0, 1, 1, 0, 0);
      addv(0, 1,  3,  0, 0, 1,  3, 0, 0, 1, 0, 0);
      addv(0, 0,  0,  0, 0, 1,  3, 0, 0, 0, 0, 1);
      addv(0, 1,  5, 59, 0, 0,  5,59, 0, 0, 0, 0);
      addv(0, 0,  0,  0, 1, 0,  6, 0, 1, 0, 0, 0);
      addv(0, 0,  0,  0, 0, 0,  6, 0, 1, 0, 1, 0);
      addv(0, 1,  3,  0, 0, 0,  3, 0, 0, 0, 1, 0);
      addv(0, 0,  0,  0, 0, 0,  3, 0, 0, 0, 0, 0);
      addv(0, 0,  0,  0, 0, 0,  3, 0, 0, 0, 0, 0);
      addv(0, 1, 23, 59, 0, 0, 23,59, 0, 0, 0, 0);
      addv(0, 0,  0,  0, 1, 0,  0, 0, 0, 0, 0, 0);
      addv(0, 1, 24,  0, 0, 0,  0, 0, 0, 0, 0, 0);
      addv(0, 1, 24,  0, 1, 0,  0, 0, 0, 0, 0, 0);
      addv(0, 1, 12, 60, 1, 0,  0, 0, 0, 0, 0, 0);
      addv(0, 1, 10, 30, 1, 0, 10,30, 1, 0, 0, 0);
      addv(0, 0,  0,  0, 1, 0, 10,31, 1, 0, 1, 0);
      addv(0, 0,  0,  0, 1, 1, 10,32, 1, 1, 0, 1);
      addv(0, 0,  0,  0, 0, 0, 10,32, 1, 1, 0, 0);
      addv(0, 1, 21,  0, 0, 0, 21, 0, 0, 1, 0, 0);
      addv(0, 0,  0,  0, 0, 0, 21, 0, 0, 1, 1, 0);
      addv(1, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
      addv(0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
      // reset while pending toward day at 06:00
      addv(0, 1,  6,  0, 0, 0,  6, 0, 1, 0, 0, 0);
      addv(0, 0,  0,  0, 0, 0,  6, 0, 1, 0, 1, 0);
      addv(1, 0,  0,  0, 1, 1,  0, 0, 0, 0, 0, 0);
      addv(0, 0,  0,  0, 0, 1,  0, 0, 0, 0, 0, 0);

      foreach (vecs[k]) begin
         drive(vecs[k].r, vecs[k].ld, vecs[k].lh, vecs[k].lm, vecs[k].tk, vecs[k].sf);
         step();
         check($sformatf("v%0d.hours", k),   int'(h0),    vecs[k].eh);
         check($sformatf("v%0d.minutes", k), int'(m0),    vecs[k].em);
         check($sformatf("v%0d.dayReq", k),  int'(dr0),   int'(vecs[k].edr));
         check($sformatf("v%0d.isDay", k),   int'(day0),  int'(vecs[k].eday));
         check($sformatf("v%0d.pending", k), int'(pend0), int'(vecs[k].epend));
         check($sformatf("v%0d.pulse", k),   int'(pul0),  int'(vecs[k].epul));
      end

      // Midnight-spanning window 22..2 on instance 1
      drive(0, 1, 21, 0, 0, 0); step(); check("wrap.h21", int'(dr1), 0);
      drive(0, 1, 22, 0, 0, 0); step(); check("wrap.h22", int'(dr1), 1);
      drive(0, 1,  1, 0, 0, 0); step(); check("wrap.h01", int'(dr1), 1);
      drive(0, 1,  2, 0, 0, 0); step(); check("wrap.h02", int'(dr1), 0);

      // Load with tickIn clears the 3-tick prescaler on instance 1
      drive(0, 0, 0, 0, 1, 0); step();
      drive(0, 0, 0, 0, 1, 0); step();
      drive(0, 1, 10, 30, 1, 0); step(); check("clr.load", int'(m1), 30);
      drive(0, 0, 0, 0, 1, 0); step(); check("clr.t1", int'(m1), 30);
      drive(0, 0, 0, 0, 1, 0); step(); check("clr.t2", int'(m1), 30);
      drive(0, 0, 0, 0, 1, 0); step(); check("clr.t3", int'(m1), 31);

      // Random stimulus against the reference model
      for (int n = 0; n < 4000; n++) begin
         bit r, ld, tk, sf;
         int lh, lm;
         r  = ($urandom_range(0, 199) == 0);
         ld = ($urandom_range(0, 19) == 0);
         lh = ($urandom_range(0, 9) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23);
         lm = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 59);
         tk = ($urandom_range(0, 3) != 0);
         sf = ($urandom_range(0, 2) == 0);
         drive(r, ld, lh, lm, tk, sf);
         step();
      end

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule

// File: doc/time_of_day_mode_ctrl.md
# time_of_day_mode_ctrl

Parametrised time-of-day keeper and day/night mode controller for the traffic-light design. Counts one-second ticks into minutes and hours and derives a day/night request from a configurable daytime window. It applies the requested mode only when the intersection controller reports a safe switch point (all-red), so a mode change never cuts into a running phase. It replaces the fixed 6:00–20:00 hour decode with a sequential, loadable, handshaked block.

## Interface
- TICKS_PER_MIN, default 60: number of tickIn pulses per minute; legal range ≥1 (set 1 for fast simulation).
- DAY_START_HOUR, default 6: first daytime hour; legal range 0–23.
- DAY_END_HOUR, default 20: first night hour after daytime; legal range 0–23.

- clk  in  1  single system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- tickIn  in  1  one-cycle enable, one per second.
- loadEn  in  1  load loadHours/loadMinutes this cycle.
- loadHours  in  5  hour to load, 0–23.
- loadMinutes  in  6  minute to load, 0–59.
- safeIn  in  1  level; intersection is at a safe switch point.
- hoursOut  out  5  current hour, 0–23.
- minutesOut  out  6  current minute, 0–59.
- dayReq  out  1  requested mode decoded from hoursOut (1 = day).
- isDay  out  1  applied mode (1 = day, 0 = night).
- pendingOut  out  1  a mode change is requested but not yet applied.
- modeChangePulse  out  1  one-cycle pulse when isDay changes.

## Operation
- Reset: hoursOut=0, minutesOut=0, tick counter=0, state NIGHT, isDay=0, pendingOut=0, modeChangePulse=0.
- Tick counter: counts 0..TICKS_PER_MIN-1 on tickIn. On tickIn at the terminal count, it clears to 0 and minutes increments.
- Minutes wrap from 59 to 0 and increment hours. Hours wrap from 23 to 0.
- Load: when loadEn=1 and loadHours≤23 and loadMinutes≤59, hours and minutes take the loaded values and the tick counter clears.
  - Load has priority over a same-cycle tickIn; that tick is discarded.
  - An out-of-range load is ignored entirely. Time and the tick counter are unchanged, and a same-cycle tickIn is still discarded.
- dayReq is combinational from the hours register:
  - START<END: dayReq = START ≤ h < END.
  - START>END (window wraps midnight): dayReq = h ≥ START or h < END.
  - START==END: dayReq = 0 always.
- FSM states: NIGHT, TO_DAY, DAY, TO_NIGHT.
  - NIGHT: dayReq&safeIn → DAY with pulse. dayReq&~safeIn → TO_DAY. Otherwise stay.
  - TO_DAY: ~dayReq → NIGHT with no pulse (request withdrawn, e.g. by load). dayReq&safeIn → DAY with pulse. Otherwise stay.
  - DAY and TO_NIGHT: mirror images of NIGHT and TO_DAY, using ~dayReq as the request.
- isDay=1 in DAY and TO_NIGHT. pendingOut=1 in TO_DAY and TO_NIGHT. Both are decoded from registered state.
- modeChangePulse is registered and high exactly in the first cycle isDay shows its new value.
- rst mid-pending forces NIGHT immediately with no pulse, even if time was in daytime. After reset, time is 00:00, so default parameters request night.

## Timing
- tickIn completing a minute at edge N: minutesOut and hoursOut update after edge N. dayReq is valid in the same cycle.
- FSM evaluates dayReq/safeIn at edge N+1. With safeIn=1, isDay and modeChangePulse change after edge N+1, giving 2 edges from the terminal tick.
- safeIn low: pendingOut rises after edge N+1. isDay changes one edge after the first cycle with safeIn=1.
- Load: new time is visible after the loadEn edge. Mode follows by the FSM rules, with a minimum of 1 further edge.
- Back-to-back tickIn every cycle is legal. No throughput limit.

## Test plan
- Reset: assert rst for 2 cycles with tickIn=1 → all outputs 0, state NIGHT, time 00:00. No pulse after release.
- TICKS_PER_MIN=1, load 19:59, safeIn=1, hold until isDay=1, then one tickIn → time 20:00, dayReq=0. isDay falls 1 edge later with a single modeChangePulse.
- Load 05:59, safeIn=0, tickIn → time 06:00, pendingOut=1 and isDay=0 held for 10 cycles. Raise safeIn → isDay=1 next edge, pulse once, pendingOut=0.
- In TO_DAY (06:00, safeIn=0), load 03:00 → next edge NIGHT, pendingOut=0, no pulse.
- Load 23:59, tickIn → 00:00. Load 24:00 → ignored, time unchanged. loadEn with tickIn in the same cycle → loaded value wins, tick counter 0.
- DAY_START_HOUR=22, DAY_END_HOUR=2: check hours 21, 22, 1, 2 give dayReq = 0, 1, 1, 0.
